rshift_ctrl: RTL and testbench

RSHIFT_CTRL -- requirements
Module: rshift_ctrl

---
 rtl/rshift_ctrl.sv | 100 ++++++++++
 tb/tb_rshift_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rshift_ctrl.sv
// Sequential logical right shifter: shifts operand a right by b bit-steps, one per clock,
// then presents the registered result and the last bit shifted out with a one-cycle done pulse.
module rshift_ctrl #(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  input  logic             aluflagin,
  output logic             busy,
  output logic             done,
  output logic [ancho-1:0] aluresult,
  output logic             aluflags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ancho-1:0] ONE = {{(ancho-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [ancho-1:0] work_q, work_d;
  logic [ancho-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [ancho-1:0] res_q, res_d;
  logic             flag_q, flag_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = a;
          cnt_d   = b;
          mode_d  = aluflagin;
          sout_d  = 1'b0;
          state_d = (b != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        sout_d = work_q[0];
        work_d = work_q >> 1;
        cnt_d  = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Results are committed here so they change only on the edge that raises done.
        done_d  = 1'b1;
        res_d   = work_q | {{(ancho-1){1'b0}}, mode_q};
        flag_d  = sout_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
    end
  end

  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done      = done_q;
  assign aluresult = res_q;
  assign aluflags  = flag_q;

endmodule

// File: tb/tb_rshift_ctrl.sv
// Bench for rshift_ctrl: cycle-level behavioural model compared every cycle,
// plus directed operations with literal expected results.
module tb_rshift_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       aluflagin;
  logic       busy;
  logic       done;
  logic [3:0] aluresult;
  logic       aluflags;

  int checks = 0;
  int errors = 0;

  rshift_ctrl #(.ancho(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .aluflagin(aluflagin),
    .busy(busy), .done(done), .aluresult(aluresult), .aluflags(aluflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an accepted op finishes b+1 edges later with (a>>b)|mode
  // and the last bit shifted out, i.e. a[b-1] when 1<=b<=4, else 0.
  int   cyc = 0;
  int   m_done_at = -1;
  bit   m_busy = 0, m_done = 0, m_flag = 0, m_prev_done = 0;
  int   m_res = 0, p_res = 0;
  bit   p_flag = 0;
  int   ai, bi;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = 0; m_flag = 0; m_done_at = -1;
    end else begin
      m_done = 0;
      if (m_busy && cyc == m_done_at) begin
        m_busy = 0; m_done = 1; m_res = p_res; m_flag = p_flag;
      end else if (!m_busy && start) begin
        ai = int'(a); bi = int'(b);
        m_busy    = 1;
        m_done_at = cyc + bi + 1;
        p_res     = (ai >> bi) | int'(aluflagin);
        p_flag    = (bi >= 1 && bi <= 4) ? bit'((ai >> (bi - 1)) & 1) : 1'b0;
      end
    end
    #1;
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("aluresult", int'(aluresult), m_res);
    check("aluflags", int'(aluflags), int'(m_flag));
    if (m_prev_done && done) check("done_twice", 1, 0);
    m_prev_done = done;
  end

  int dut_dones = 0;
  always @(negedge clk) if (done === 1'b1) dut_dones++;

  // Called at a negedge with the DUT idle; pulses start for one edge.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tm,
                        input logic [3:0] er, input logic ef, input string nm);
    int e, bc;
    a = ta; b = tb; aluflagin = tm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'($urandom); b = 4'($urandom); aluflagin = 1'($urandom);
    e = 0;
    bc = busy ? 1 : 0;
    while (done !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
      if (busy === 1'b1) bc++;
    end
    check({nm, "_latency"}, e, int'(tb) + 1);
    check({nm, "_busycycles"}, bc, int'(tb) + 1);
    check({nm, "_result"}, int'(aluresult), int'(er));
    check({nm, "_flag"}, int'(aluflags), int'(ef));
  endtask

  initial begin
    int d0, last, spacing_ok;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; aluflagin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(aluresult), 0);
    check("reset_flag", int'(aluflags), 0);
    rst = 1'b0;

    run_op(4'b1011, 4'd2, 1'b0, 4'b0010, 1'b1, "op_b2");
    run_op(4'b1100, 4'd3, 1'b1, 4'b0001, 1'b1, "op_b3_mode");
    run_op(4'b0110, 4'd0, 1'b0, 4'b0110, 1'b0, "op_b0");
    run_op(4'b1001, 4'd4, 1'b0, 4'b0000, 1'b1, "op_b4");
    run_op(4'b1001, 4'd7, 1'b0, 4'b0000, 1'b0, "op_b7");
    run_op(4'b1001, 4'd15, 1'b1, 4'b0001, 1'b0, "op_b15_mode");

    // start pulsed during SHIFT must be dropped
    @(negedge clk);
    d0 = dut_dones;
    a = 4'b1111; b = 4'd3; aluflagin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'b0000; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 4'b0101;
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    check("busy_ignore_result", int'(aluresult), 1);
    check("busy_ignore_flag", int'(aluflags), 1);
    repeat (10) @(negedge clk);
    check("busy_ignore_donecount", dut_dones - d0, 1);

    // reset mid-SHIFT aborts with no done pulse
    d0 = dut_dones;
    a = 4'b1010; b = 4'd5; aluflagin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_result", int'(aluresult), 0);
    check("rst_mid_flag", int'(aluflags), 0);
    repeat (6) @(negedge clk);
    check("rst_mid_nodone", dut_dones - d0, 0);
    rst = 1'b0;
    run_op(4'b0100, 4'd2, 1'b0, 4'b0001, 1'b0, "after_rst");

    // start held high: completions spaced b+2 cycles apart
    a = 4'b0111; b = 4'd3; aluflagin = 1'b0; start = 1'b1;
    last = -1; spacing_ok = 1;
    d0 = dut_dones;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (last >= 0 && i - last != 5) spacing_ok = 0;
        last = i;
      end
    end
    start = 1'b0;
    check("b2b_spacing", spacing_ok, 1);
    check("b2b_count", dut_dones - d0, 8);
    repeat (8) @(negedge clk);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 2) != 0);
      a         = 4'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      aluflagin = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
